fifo_burst_reader: RTL and testbench
====================================

Name: fifo_burst_reader

Overview:
- Read-side controller for the data-path FIFO.
- On a start command it pops exactly `len` words from the FIFO, which presents read data combinationally at its read pointer.
- It presents each word on a registered valid/ready stream toward the PE-array feeder, with a last-word flag.
- It signals done when the final word has been accepted downstream.

Parameters:
- DATA_WIDTH, 32, width of FIFO words and stream data.
- LEN_WIDTH, 8, width of the burst length; max burst is 2^LEN_WIDTH-1 words.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  single-cycle burst request; sampled only in IDLE.
- len  input  LEN_WIDTH  burst length; captured with start.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  one-cycle pulse when the burst completes.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rden  output  1  FIFO pop; pointer advances at this clock edge.
- fifo_rdata  input  DATA_WIDTH  FIFO head word, valid whenever fifo_empty=0.
- m_valid  output  1  stream data valid.
- m_ready  input  1  downstream accept.
- m_data  output  DATA_WIDTH  stream data (registered).
- m_last  output  1  high with the final word of the burst.

Behaviour:
- Reset (synchronous, rst=1 at a clock edge):
  - state=IDLE; remaining=0.
  - m_valid=0, m_last=0, m_data=0, done=0, fifo_rden=0.
  - FIFO contents and pointers are not touched; unread words stay in the FIFO.
  - A reset mid-burst abandons the burst with no done pulse.
- States IDLE, RUN, DRAIN.
- IDLE:
  - start=1 and len!=0: capture remaining=len, go to RUN.
  - start=1 and len==0: stay in IDLE, pulse done next cycle, no FIFO access.
- RUN:
  - fifo_rden is combinational: (state==RUN) & (remaining!=0) & !fifo_empty & (!m_valid | m_ready).
  - Never assert fifo_rden while fifo_empty=1; the FIFO has no underflow protection.
  - On a pop: m_data<=fifo_rdata, m_valid<=1, m_last<=(remaining==1), remaining<=remaining-1.
  - Pop on the cycle remaining==1: go to DRAIN.
- Stream register:
  - m_valid&m_ready with no pop in the same cycle: m_valid<=0, m_last<=0.
  - Pop together with acceptance: back-to-back, one word per cycle sustained.
  - m_data, m_last held stable while m_valid=1 and m_ready=0.
- DRAIN:
  - No pops.
  - When m_valid&m_ready&m_last: m_valid<=0, go to IDLE, done=1 for exactly the next cycle.
- Latency: a word popped at edge N is on m_data with m_valid=1 after edge N.
- Throughput: 1 word/clk when the FIFO is non-empty and m_ready=1.
- FIFO empty mid-burst: stall in RUN with no pop; resume when fifo_empty falls.
- start while busy: ignored; len not re-captured.
- start on the done cycle: accepted, because state is already IDLE.
- remaining arithmetic: unsigned LEN_WIDTH; decrement only on pop; never wraps below 0.
- busy = (state!=IDLE).

Decomposition:
- Shared data-path package holds:
  - state encoding constants RD_IDLE=2'd0, RD_RUN=2'd1, RD_DRAIN=2'd2;
  - default DATA_WIDTH;
  - the LEN_WIDTH default.
- Natural sub-module: stream_out_reg, a one-entry valid/ready output register with load/accept/hold, reusable by other FIFO consumers.
- FSM and counter stay in the top.

Test Plan:
- Basic burst: FIFO preloaded 0x11,0x22,0x33,0x44; start len=4, m_ready=1 → four consecutive m_valid cycles with data 0x11..0x44, m_last only on 0x44, done one cycle after, FIFO empty.
- Backpressure: len=3, m_ready toggled 1,0,0,1,0,1… → m_data held stable while stalled, no fifo_rden while m_valid&!m_ready, order preserved, exactly 3 pops.
- Underflow guard: FIFO holds 2 words, len=5 → 2 words delivered, then fifo_rden=0 and busy=1 while empty; push 3 more → remaining 3 delivered, m_last on the 5th, done.
- Zero length: start len=0 → no fifo_rden, m_valid=0, done pulse next cycle, busy stays 0.
- Start while busy: during a len=4 burst, pulse start len=9 → ignored, exactly 4 words; start on the done cycle with len=2 → second burst of 2.
- Reset mid-burst: rst=1 after 2 of 6 words → next cycle m_valid=0, busy=0, done=0; 4 words remain in the FIFO and are read by a new len=4 burst.

Source files
------------

// File: rtl/fifo_burst_reader_pkg.sv
// -----------------------------------------------------------------------------
// fifo_burst_reader_pkg
// Shared definitions for the data-path FIFO read side: state encoding of the
// burst reader FSM and the default word / burst-length widths.
// -----------------------------------------------------------------------------
package fifo_burst_reader_pkg;

    // Default width of FIFO words and of the outgoing stream data.
    localparam int RD_DATA_WIDTH = 32;

    // Default width of the burst length; longest burst is 2^RD_LEN_WIDTH-1.
    localparam int RD_LEN_WIDTH = 8;

    // Burst reader states.
    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_RUN   = 2'd1,
        RD_DRAIN = 2'd2
    } rd_state_e;

endpackage : fifo_burst_reader_pkg

// File: rtl/fifo_burst_reader_stream_out_reg.sv
// -----------------------------------------------------------------------------
// stream_out_reg
// One-entry valid/ready output register. A load captures a word and its last
// flag and raises valid; an acceptance (valid & ready) without a load clears
// valid and last; otherwise the entry holds. Load and acceptance in the same
// cycle replace the entry, giving one word per clock sustained.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   load_i       capture load_data_i / load_last_i this cycle
//   load_data_i  word to capture
//   load_last_i  last-word flag to capture
//   ready_i      downstream accept
//   valid_o      entry holds a word
//   data_o       registered word
//   last_o       registered last-word flag
// -----------------------------------------------------------------------------
module stream_out_reg #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] load_data_i,
    input  logic                  load_last_i,
    input  logic                  ready_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  last_o
);

    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= load_data_i;
            last_q  <= load_last_i;
        end else if (valid_q && ready_i) begin
            // Data is left as-is after acceptance; only valid/last drop.
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign last_o  = last_q;

endmodule : stream_out_reg

// File: rtl/fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// fifo_burst_reader
// Read-side controller for the data-path FIFO. A start command pops exactly
// len words from a show-ahead FIFO and presents them on a registered
// valid/ready stream with a last-word flag; done pulses for one cycle once the
// final word is accepted downstream.
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   start       single-cycle burst request, sampled only in IDLE
//   len         burst length, captured with start
//   busy        high in RUN and DRAIN
//   done        one-cycle pulse when the burst completes
//   fifo_empty  FIFO empty flag
//   fifo_rden   FIFO pop (combinational)
//   fifo_rdata  FIFO head word, valid whenever fifo_empty=0
//   m_valid     stream data valid
//   m_ready     downstream accept
//   m_data      stream data (registered)
//   m_last      high with the final word of the burst
// -----------------------------------------------------------------------------
module fifo_burst_reader
    import fifo_burst_reader_pkg::*;
#(
    parameter int DATA_WIDTH = RD_DATA_WIDTH,
    parameter int LEN_WIDTH  = RD_LEN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    input  logic                  fifo_empty,
    output logic                  fifo_rden,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);

    rd_state_e            state_q, state_d;
    logic [LEN_WIDTH-1:0] remaining_q, remaining_d;
    logic                 done_q, done_d;
    logic                 last_pop;

    // Pop only when there is a word to take, words left in the burst, and the
    // output register is free or being emptied this cycle. The empty check is
    // essential: the FIFO itself has no underflow protection.
    assign fifo_rden = (state_q == RD_RUN) && (remaining_q != '0) && !fifo_empty
                       && (!m_valid || m_ready);

    assign last_pop = (remaining_q == LEN_WIDTH'(1));

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        unique case (state_q)
            RD_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        state_d     = RD_RUN;
                        remaining_d = len;
                    end else begin
                        // Empty burst completes immediately without FIFO access.
                        done_d = 1'b1;
                    end
                end
            end
            RD_RUN: begin
                if (fifo_rden) begin
                    remaining_d = remaining_q - LEN_WIDTH'(1);
                    if (last_pop) begin
                        state_d = RD_DRAIN;
                    end
                end
            end
            RD_DRAIN: begin
                if (m_valid && m_ready && m_last) begin
                    state_d = RD_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = RD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RD_IDLE;
            remaining_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            done_q      <= done_d;
        end
    end

    stream_out_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_stream_out (
        .clk         (clk),
        .rst         (rst),
        .load_i      (fifo_rden),
        .load_data_i (fifo_rdata),
        .load_last_i (last_pop),
        .ready_i     (m_ready),
        .valid_o     (m_valid),
        .data_o      (m_data),
        .last_o      (m_last)
    );

    assign busy = (state_q != RD_IDLE);
    assign done = done_q;

endmodule : fifo_burst_reader

// File: tb/tb_fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_burst_reader
// Directed self-checking bench for fifo_burst_reader. A small show-ahead FIFO
// model feeds the reader; a monitor records every accepted word, pops, done
// pulses and protocol violations; the initial block walks through the
// scenarios and compares against hand-computed values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fifo_burst_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        busy;
    logic        done;
    logic        fifo_empty;
    logic        fifo_rden;
    logic [31:0] fifo_rdata;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        m_last;

    always #5 clk = ~clk;

    fifo_burst_reader #(.DATA_WIDTH(32), .LEN_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .fifo_empty (fifo_empty),
        .fifo_rden  (fifo_rden),
        .fifo_rdata (fifo_rdata),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last)
    );

    // Show-ahead FIFO model: written by the stimulus, popped by the DUT.
    logic [31:0] fmem [0:63];
    logic [5:0]  wr_ptr = '0;
    logic [5:0]  rd_ptr = '0;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_rdata = fmem[rd_ptr];

    // Monitor state.
    int          cyc = 0;
    int          pops = 0;
    int          done_cnt = 0;
    int          done_cyc = -1;
    int          last_cyc = -1;
    int          underflow_err = 0;
    int          stall_pop_err = 0;
    int          hold_err = 0;
    logic        hold_pending = 1'b0;
    logic [31:0] hold_data;
    logic        hold_last;
    logic [31:0] acc_q[$];
    logic        accl_q[$];
    int          accc_q[$];

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (fifo_rden) begin
            rd_ptr <= rd_ptr + 6'd1;
            pops = pops + 1;
            if (fifo_empty) underflow_err = underflow_err + 1;
            if (m_valid && !m_ready) stall_pop_err = stall_pop_err + 1;
        end
        if (hold_pending && (!m_valid || m_data !== hold_data || m_last !== hold_last))
            hold_err = hold_err + 1;
        hold_pending = m_valid && !m_ready && !rst;
        hold_data    = m_data;
        hold_last    = m_last;
        if (m_valid && m_ready && !rst) begin
            acc_q.push_back(m_data);
            accl_q.push_back(m_last);
            accc_q.push_back(cyc);
            if (m_last) last_cyc = cyc;
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        fmem[wr_ptr] = w;
        wr_ptr = wr_ptr + 6'd1;
    endtask

    task automatic do_start(input logic [7:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
        len   = 8'd0;
    endtask

    // Run with a repeating m_ready pattern until done rises (bounded).
    task automatic run_until_done(input string tag, input int maxc,
                                  input logic [7:0] pat, input int plen);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            m_ready = pat[i % plen];
            tick();
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    endtask

    task automatic chk_word(input string tag, input int idx,
                            input logic [31:0] d, input logic l);
        if (idx < acc_q.size()) begin
            chk({tag, "_data"}, acc_q[idx], d);
            chk({tag, "_last"}, {31'd0, accl_q[idx]}, {31'd0, l});
        end else begin
            chk({tag, "_missing"}, 32'(acc_q.size()), 32'(idx + 1));
        end
    endtask

    int b_acc, b_pops, b_done;

    task automatic mark();
        b_acc  = acc_q.size();
        b_pops = pops;
        b_done = done_cnt;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = 8'd0; m_ready = 1'b0;
        tick(); tick();

        // ---- reset state ----
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_m_last",  {31'd0, m_last},  32'd0);
        chk("rst_m_data",  m_data,           32'd0);
        chk("rst_done",    {31'd0, done},    32'd0);
        chk("rst_busy",    {31'd0, busy},    32'd0);
        chk("rst_rden",    {31'd0, fifo_rden}, 32'd0);
        rst = 1'b0;
        tick();

        // ---- basic burst ----
        push(32'h11); push(32'h22); push(32'h33); push(32'h44);
        mark();
        m_ready = 1'b1;
        do_start(8'd4);
        chk("basic_busy", {31'd0, busy}, 32'd1);
        run_until_done("basic", 20, 8'hFF, 8);
        tick();
        $display("[TB] basic burst: %0d words accepted", acc_q.size() - b_acc);
        chk("basic_count", 32'(acc_q.size() - b_acc), 32'd4);
        chk_word("basic_w0", b_acc + 0, 32'h11, 1'b0);
        chk_word("basic_w1", b_acc + 1, 32'h22, 1'b0);
        chk_word("basic_w2", b_acc + 2, 32'h33, 1'b0);
        chk_word("basic_w3", b_acc + 3, 32'h44, 1'b1);
        if (acc_q.size() - b_acc >= 4)
            chk("basic_b2b", 32'(accc_q[b_acc + 3] - accc_q[b_acc]), 32'd3);
        chk("basic_done_cnt", 32'(done_cnt - b_done), 32'd1);
        chk("basic_done_lat", 32'(done_cyc - last_cyc), 32'd1);
        chk("basic_done_pulse", {31'd0, done}, 32'd0);
        chk("basic_fifo_empty", {31'd0, fifo_empty}, 32'd1);
        chk("basic_busy_end", {31'd0, busy}, 32'd0);

        // ---- backpressure: ready 1,0,0,1,0,1,1,1 repeating ----
        push(32'hA1); push(32'hA2); push(32'hA3);
        mark();
        m_ready = 1'b1;
        do_start(8'd3);
        run_until_done("bp", 40, 8'hE9, 8);
        m_ready = 1'b1;
        tick();
        $display("[TB] backpressure burst: %0d words accepted", acc_q.size() - b_acc);
        chk("bp_count", 32'(acc_q.size() - b_acc), 32'd3);
        chk_word("bp_w0", b_acc + 0, 32'hA1, 1'b0);
        chk_word("bp_w1", b_acc + 1, 32'hA2, 1'b0);
        chk_word("bp_w2", b_acc + 2, 32'hA3, 1'b1);
        chk("bp_pops", 32'(pops - b_pops), 32'd3);
        chk("bp_done_cnt", 32'(done_cnt - b_done), 32'd1);

        // ---- underflow guard ----
        push(32'hB1); push(32'hB2);
        mark();
        m_ready = 1'b1;
        do_start(8'd5);
        for (int i = 0; i < 8; i++) tick();
        $display("[TB] underflow stall: %0d words so far", acc_q.size() - b_acc);
        chk("uf_stall_count", 32'(acc_q.size() - b_acc), 32'd2);
        chk("uf_stall_busy", {31'd0, busy}, 32'd1);
        chk("uf_stall_rden", {31'd0, fifo_rden}, 32'd0);
        chk("uf_stall_valid", {31'd0, m_valid}, 32'd0);
        chk("uf_stall_done", 32'(done_cnt - b_done), 32'd0);
        push(32'hB3); push(32'hB4); push(32'hB5);
        run_until_done("uf", 20, 8'hFF, 8);
        tick();
        $display("[TB] underflow resume: %0d words accepted", acc_q.size() - b_acc);
        chk("uf_count", 32'(acc_q.size() - b_acc), 32'd5);
        chk_word("uf_w1", b_acc + 1, 32'hB2, 1'b0);
        chk_word("uf_w2", b_acc + 2, 32'hB3, 1'b0);
        chk_word("uf_w4", b_acc + 4, 32'hB5, 1'b1);
        chk("uf_pops", 32'(pops - b_pops), 32'd5);
        chk("uf_done_cnt", 32'(done_cnt - b_done), 32'd1);

        // ---- zero length ----
        mark();
        do_start(8'd0);
        $display("[TB] zero-length start: done=%0d busy=%0d", done, busy);
        chk("zero_done", {31'd0, done}, 32'd1);
        chk("zero_busy", {31'd0, busy}, 32'd0);
        chk("zero_valid", {31'd0, m_valid}, 32'd0);
        chk("zero_rden", {31'd0, fifo_rden}, 32'd0);
        tick();
        chk("zero_done_drop", {31'd0, done}, 32'd0);
        chk("zero_pops", 32'(pops - b_pops), 32'd0);

        // ---- start while busy, then start on the done cycle ----
        push(32'hC1); push(32'hC2); push(32'hC3); push(32'hC4);
        push(32'hD1); push(32'hD2);
        mark();
        m_ready = 1'b1;
        do_start(8'd4);
        tick();
        do_start(8'd9);
        run_until_done("sb1", 20, 8'hFF, 8);
        do_start(8'd2);
        chk("sb_restart_busy", {31'd0, busy}, 32'd1);
        run_until_done("sb2", 20, 8'hFF, 8);
        tick();
        $display("[TB] start-while-busy: %0d words accepted", acc_q.size() - b_acc);
        chk("sb_count", 32'(acc_q.size() - b_acc), 32'd6);
        chk_word("sb_w3", b_acc + 3, 32'hC4, 1'b1);
        chk_word("sb_w4", b_acc + 4, 32'hD1, 1'b0);
        chk_word("sb_w5", b_acc + 5, 32'hD2, 1'b1);
        chk("sb_pops", 32'(pops - b_pops), 32'd6);
        chk("sb_done_cnt", 32'(done_cnt - b_done), 32'd2);
        chk("sb_fifo_empty", {31'd0, fifo_empty}, 32'd1);

        // ---- reset mid-burst ----
        push(32'hE1); push(32'hE2); push(32'hE3);
        push(32'hE4); push(32'hE5); push(32'hE6);
        mark();
        m_ready = 1'b1;
        do_start(8'd6);
        tick();               // pop E1
        tick();               // accept E1, pop E2
        m_ready = 1'b0;       // E2 stalls in the output register
        rst = 1'b1;
        tick();
        rst = 1'b0;
        $display("[TB] reset mid-burst: valid=%0d busy=%0d left=%0d", m_valid, busy, wr_ptr - rd_ptr);
        chk("mrst_valid", {31'd0, m_valid}, 32'd0);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_done", {31'd0, done}, 32'd0);
        chk("mrst_left", {26'd0, 6'(wr_ptr - rd_ptr)}, 32'd4);
        mark();
        m_ready = 1'b1;
        do_start(8'd4);
        run_until_done("mrst", 20, 8'hFF, 8);
        tick();
        $display("[TB] post-reset burst: %0d words accepted", acc_q.size() - b_acc);
        chk("mrst_count", 32'(acc_q.size() - b_acc), 32'd4);
        chk_word("mrst_w0", b_acc + 0, 32'hE3, 1'b0);
        chk_word("mrst_w3", b_acc + 3, 32'hE6, 1'b1);
        chk("mrst_done_cnt", 32'(done_cnt - b_done), 32'd1);

        // ---- protocol monitors over the whole run ----
        chk("mon_underflow", 32'(underflow_err), 32'd0);
        chk("mon_stall_pop", 32'(stall_pop_err), 32'd0);
        chk("mon_hold", 32'(hold_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_fifo_burst_reader
